// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the counter bank and its channels.
package counter_pkg;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    AUTO_UP = 1'b0,
    AUTO_DN = 1'b1
  } auto_dir_e;

  // All-ones value for a counter of the given width (1..32).
  function automatic logic [31:0] max_val(input int unsigned width);
    logic [63:0] one;
    one = 64'd1;
    max_val = 32'((one << width) - 64'd1);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter with clear/load/auto-step priority, wrap or saturate limits,
// registered equality flags and a terminal-count pulse.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic             down,
  input  logic             auto_en,
  input  logic             auto_dn,
  input  logic             sat,
  input  logic             tick,
  input  logic [WIDTH-1:0] cmp_value,
  output logic [WIDTH-1:0] count,
  output logic             eq_zero,
  output logic             eq_max,
  output logic             eq_cmp,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             eq_zero_q, eq_zero_d;
  logic             eq_max_q, eq_max_d;
  logic             eq_cmp_q, eq_cmp_d;
  logic             inc, dec;

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    // A manual trigger in a tick cycle swallows the auto step.
    if (up) begin
      inc = 1'b1;
    end else if (down) begin
      dec = 1'b1;
    end else if (auto_en && tick) begin
      if (auto_dir_e'(auto_dn) == AUTO_DN) dec = 1'b1;
      else                                 inc = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (inc) begin
      if (count_q == MAX) begin
        if (cnt_mode_e'(sat) == CNT_MODE_WRAP) begin
          count_d = '0;
          tc_d    = 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec) begin
      if (count_q == '0) begin
        if (cnt_mode_e'(sat) == CNT_MODE_WRAP) begin
          count_d = MAX;
          tc_d    = 1'b1;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Flags look at the registered count, so they trail it by one cycle.
  always_comb begin
    eq_zero_d = (count_q == '0);
    eq_max_d  = (count_q == MAX);
    eq_cmp_d  = (count_q == cmp_value);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      tc_q      <= 1'b0;
      eq_zero_q <= 1'b0;
      eq_max_q  <= 1'b0;
      eq_cmp_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      eq_zero_q <= eq_zero_d;
      eq_max_q  <= eq_max_d;
      eq_cmp_q  <= eq_cmp_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign eq_zero = eq_zero_q;
  assign eq_max  = eq_max_q;
  assign eq_cmp  = eq_cmp_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH independent up/down counters sharing one programmable prescaler tick.
module counter_bank
  import counter_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div_period,
  input  logic [N_CH-1:0]       ch_clear,
  input  logic [N_CH-1:0]       ch_load,
  input  logic [N_CH*WIDTH-1:0] load_value,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       ch_auto_dn,
  input  logic [N_CH-1:0]       ch_sat,
  input  logic [N_CH*WIDTH-1:0] cmp_value,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       eq_zero,
  output logic [N_CH-1:0]       eq_max,
  output logic [N_CH-1:0]       eq_cmp,
  output logic [N_CH-1:0]       tc,
  output logic                  tick
);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 tick_q, tick_d;

  // div_period is only sampled on reload, so changes apply from the next period.
  always_comb begin
    if (presc_q == '0) begin
      presc_d = div_period;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q - 1'b1;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      presc_q <= div_period;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (sys_clk),
      .reset      (reset),
      .clear      (ch_clear[i]),
      .load       (ch_load[i]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .up         (ch_up[i]),
      .down       (ch_down[i]),
      .auto_en    (ch_auto[i]),
      .auto_dn    (ch_auto_dn[i]),
      .sat        (ch_sat[i]),
      .tick       (tick_q),
      .cmp_value  (cmp_value[i*WIDTH +: WIDTH]),
      .count      (count[i*WIDTH +: WIDTH]),
      .eq_zero    (eq_zero[i]),
      .eq_max     (eq_max[i]),
      .eq_cmp     (eq_cmp[i]),
      .tc         (tc[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed plus randomized bench for counter_bank against a cycle-level behavioural model.
module tb_counter_bank;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DIV_WIDTH = 24;
  localparam int          MAXV      = (1 << WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DIV_WIDTH-1:0]  div_period;
  logic [N_CH-1:0]       ch_clear, ch_load, ch_up, ch_down, ch_auto, ch_auto_dn, ch_sat;
  logic [N_CH*WIDTH-1:0] load_value, cmp_value;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       eq_zero, eq_max, eq_cmp, tc;
  logic                  tick;

  int checks = 0;
  int errors = 0;

  // Reference state: counter values as plain integers, flags as bits.
  int  m_cnt [N_CH];
  bit  m_ez [N_CH], m_em [N_CH], m_ec [N_CH], m_tc [N_CH];
  bit  m_tick;
  longint m_rem;   // cycles left before the prescaler fires

  always #5 clk = ~clk;

  counter_bank #(
    .N_CH(N_CH), .WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .sys_clk(clk), .reset(reset), .div_period(div_period),
    .ch_clear(ch_clear), .ch_load(ch_load), .load_value(load_value),
    .ch_up(ch_up), .ch_down(ch_down), .ch_auto(ch_auto), .ch_auto_dn(ch_auto_dn),
    .ch_sat(ch_sat), .cmp_value(cmp_value), .count(count), .eq_zero(eq_zero),
    .eq_max(eq_max), .eq_cmp(eq_cmp), .tc(tc), .tick(tick)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int old, lv, cv, nxt;
    bit t;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = 0; m_ez[i] = 0; m_em[i] = 0; m_ec[i] = 0; m_tc[i] = 0;
      end
      m_tick = 0;
      m_rem  = longint'(div_period);
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      old = m_cnt[i];
      lv  = int'(load_value[i*WIDTH +: WIDTH]);
      cv  = int'(cmp_value[i*WIDTH +: WIDTH]);
      m_ez[i] = (old == 0);
      m_em[i] = (old == MAXV);
      m_ec[i] = (old == cv);
      t   = 0;
      nxt = old;
      if (ch_clear[i])     nxt = 0;
      else if (ch_load[i]) nxt = lv;
      else if (ch_up[i] || (!ch_down[i] && ch_auto[i] && m_tick && !ch_auto_dn[i])) begin
        if (old == MAXV) begin nxt = ch_sat[i] ? MAXV : 0; t = !ch_sat[i]; end
        else nxt = old + 1;
      end else if (ch_down[i] || (ch_auto[i] && m_tick && ch_auto_dn[i])) begin
        if (old == 0) begin nxt = ch_sat[i] ? 0 : MAXV; t = !ch_sat[i]; end
        else nxt = old - 1;
      end
      m_cnt[i] = nxt;
      m_tc[i]  = t;
    end
    m_tick = (m_rem == 0);
    m_rem  = (m_rem == 0) ? longint'(div_period) : m_rem - 1;
  endtask

  task automatic check_all();
    logic [N_CH*WIDTH-1:0] e_cnt;
    logic [N_CH-1:0] e_ez, e_em, e_ec, e_tc;
    for (int i = 0; i < N_CH; i++) begin
      e_cnt[i*WIDTH +: WIDTH] = WIDTH'(m_cnt[i]);
      e_ez[i] = m_ez[i]; e_em[i] = m_em[i]; e_ec[i] = m_ec[i]; e_tc[i] = m_tc[i];
    end
    chk("count",   64'(count),   64'(e_cnt));
    chk("eq_zero", 64'(eq_zero), 64'(e_ez));
    chk("eq_max",  64'(eq_max),  64'(e_em));
    chk("eq_cmp",  64'(eq_cmp),  64'(e_ec));
    chk("tc",      64'(tc),      64'(e_tc));
    chk("tick",    64'(tick),    64'(m_tick));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    ch_load = '0;
    ch_up   = '0;
    ch_down = '0;
  endtask

  int n_ticks;
  int ch0_saved, ch3_saved;

  initial begin
    reset = 1'b1; div_period = 24'd3;
    ch_clear = '0; ch_load = '0; ch_up = '0; ch_down = '0;
    ch_auto = '0; ch_auto_dn = '0; ch_sat = '0;
    load_value = '0; cmp_value = '0;
    m_tick = 0; m_rem = 3;
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i] = 0; m_ez[i] = 0; m_em[i] = 0; m_ec[i] = 0; m_tc[i] = 0;
    end

    // Test 1: reset and idle
    for (int k = 0; k < 3; k++) step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_eq_zero", 64'(eq_zero), 64'd0);
    reset = 1'b0;
    step();
    chk("post_rst_eq_zero", 64'(eq_zero), 64'hF);
    for (int k = 0; k < 3; k++) step();

    // Test 2: prescaler and auto count from a fresh reset
    reset = 1'b1; ch_auto[0] = 1'b1;
    step();
    reset = 1'b0;
    n_ticks = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (tick) n_ticks++;
    end
    chk("ticks_in_16", 64'(n_ticks), 64'd4);
    chk("ch0_auto_16", 64'(count[WIDTH-1:0]), 64'd3);
    div_period = '0;
    for (int k = 0; k < 4; k++) step();
    n_ticks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (tick) n_ticks++;
    end
    chk("ticks_div0", 64'(n_ticks), 64'd8);
    ch_auto = '0;

    // Test 3: wrap up and down on ch0
    ch_load[0] = 1'b1; load_value[WIDTH-1:0] = 8'hFE;
    step();
    chk("wrap_load", 64'(count[WIDTH-1:0]), 64'hFE);
    ch_up[0] = 1'b1; step();
    chk("wrap_ff", 64'(count[WIDTH-1:0]), 64'hFF);
    chk("wrap_ff_tc", 64'(tc[0]), 64'd0);
    ch_up[0] = 1'b1; step();
    chk("wrap_00", 64'(count[WIDTH-1:0]), 64'h00);
    chk("wrap_00_tc", 64'(tc[0]), 64'd1);
    chk("wrap_eq_max", 64'(eq_max[0]), 64'd1);
    step();
    chk("wrap_tc_end", 64'(tc[0]), 64'd0);
    chk("wrap_eq_max_end", 64'(eq_max[0]), 64'd0);
    ch_down[0] = 1'b1; step();
    chk("wrap_dn_ff", 64'(count[WIDTH-1:0]), 64'hFF);
    chk("wrap_dn_tc", 64'(tc[0]), 64'd1);

    // Test 4: saturate at both limits
    ch_sat[0] = 1'b1;
    ch_up[0] = 1'b1; step();
    chk("sat_ff", 64'(count[WIDTH-1:0]), 64'hFF);
    chk("sat_ff_tc", 64'(tc[0]), 64'd0);
    ch_load[0] = 1'b1; load_value[WIDTH-1:0] = 8'h00; step();
    ch_down[0] = 1'b1; step();
    chk("sat_00", 64'(count[WIDTH-1:0]), 64'h00);
    chk("sat_00_tc", 64'(tc[0]), 64'd0);
    ch_sat[0] = 1'b0;

    // Test 5: priority on ch1
    load_value[WIDTH +: WIDTH] = 8'h55;
    ch_clear[1] = 1'b1; ch_load[1] = 1'b1; ch_up[1] = 1'b1; step();
    ch_clear[1] = 1'b0;
    chk("prio_clear", 64'(count[WIDTH +: WIDTH]), 64'h00);
    ch_load[1] = 1'b1; ch_up[1] = 1'b1; step();
    chk("prio_load", 64'(count[WIDTH +: WIDTH]), 64'h55);
    ch_up[1] = 1'b1; ch_down[1] = 1'b1; step();
    chk("prio_updown", 64'(count[WIDTH +: WIDTH]), 64'h56);
    for (int k = 0; k < 8 && !m_tick; k++) step();
    chk("tick_ready", 64'(m_tick), 64'(tick));
    ch_auto[1] = 1'b1; ch_up[1] = 1'b1; step();
    ch_auto[1] = 1'b0;
    chk("prio_up_tick", 64'(count[WIDTH +: WIDTH]), 64'h57);

    // Test 6: compare on ch1, ch2 held in clear, others isolated
    cmp_value[WIDTH +: WIDTH] = 8'h08;
    ch_clear[2] = 1'b1;
    ch_load[1] = 1'b1; load_value[WIDTH +: WIDTH] = 8'h00; step();
    ch0_saved = m_cnt[0]; ch3_saved = m_cnt[3];
    for (int k = 0; k < 8; k++) begin
      ch_up[1] = 1'b1; ch_up[2] = 1'b1; step();
    end
    chk("cmp_cnt8", 64'(count[WIDTH +: WIDTH]), 64'h08);
    chk("cmp_early", 64'(eq_cmp[1]), 64'd0);
    step();
    chk("cmp_rise", 64'(eq_cmp[1]), 64'd1);
    chk("iso_ch0", 64'(count[0 +: WIDTH]), 64'(ch0_saved));
    chk("iso_ch2", 64'(count[2*WIDTH +: WIDTH]), 64'd0);
    chk("iso_ch3", 64'(count[3*WIDTH +: WIDTH]), 64'(ch3_saved));
    ch_clear[2] = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      ch_clear   = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
      ch_load    = N_CH'($urandom) & N_CH'($urandom);
      ch_up      = N_CH'($urandom);
      ch_down    = N_CH'($urandom);
      ch_auto    = N_CH'($urandom);
      ch_auto_dn = N_CH'($urandom);
      if ($urandom_range(0, 15) == 0) ch_sat = N_CH'($urandom);
      if ($urandom_range(0, 31) == 0) div_period = DIV_WIDTH'($urandom_range(0, 5));
      for (int i = 0; i < N_CH; i++) begin
        load_value[i*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 0) ?
            WIDTH'($urandom_range(MAXV - 2, MAXV)) : WIDTH'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) cmp_value[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 4));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
